// File: rtl/mem_stage_access.sv
// MEM stage of the 16-bit pipelined CPU: issues loads/stores over a req/ack data-memory port,
// stalls upstream while an access is outstanding and registers the MEM/WB payload.
module mem_stage_access #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] ALU_Result_in,
    input  logic [WORD_SIZE-1:0] r_data2_in,
    input  logic [1:0]           rd_in,
    input  logic                 MemRead_in,
    input  logic                 MemWrite_in,
    input  logic                 RegWrite_in,
    input  logic                 MemtoReg_in,
    input  logic                 is_wwd_in,
    output logic                 stall_out,
    output logic                 d_req,
    output logic                 d_we,
    output logic [WORD_SIZE-1:0] d_addr,
    output logic [WORD_SIZE-1:0] d_wdata,
    input  logic [WORD_SIZE-1:0] d_rdata,
    input  logic                 d_ack,
    output logic [WORD_SIZE-1:0] mem_rdata_out,
    output logic [WORD_SIZE-1:0] ALU_Result_out,
    output logic [1:0]           rd_out,
    output logic                 RegWrite_out,
    output logic                 MemtoReg_out,
    output logic                 is_wwd_out,
    output logic                 mem_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 d_req_q, d_req_d;
    logic                 d_we_q, d_we_d;
    logic [WORD_SIZE-1:0] d_addr_q, d_addr_d;
    logic [WORD_SIZE-1:0] d_wdata_q, d_wdata_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic [WORD_SIZE-1:0] alu_q, alu_d;
    logic [1:0]           rd_q, rd_d;
    logic                 rw_q, rw_d;
    logic                 m2r_q, m2r_d;
    logic                 wwd_q, wwd_d;
    logic                 err_q, err_d;

    logic memop;
    logic at_limit;

    assign memop    = MemRead_in | MemWrite_in;
    assign at_limit = (cnt_q == CNT_W'(TIMEOUT));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack wins over a simultaneous timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (memop) state_d = ACCESS;
            ACCESS:  if (d_ack || at_limit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/next-value logic for the memory port and MEM/WB payload
    always_comb begin
        stall_out = 1'b0;
        cnt_d     = cnt_q;
        d_req_d   = d_req_q;
        d_we_d    = d_we_q;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;
        rdata_d   = rdata_q;
        alu_d     = alu_q;
        rd_d      = rd_q;
        rw_d      = rw_q;
        m2r_d     = m2r_q;
        wwd_d     = wwd_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (memop) begin
                    stall_out = 1'b1;
                    cnt_d     = '0;
                    d_req_d   = 1'b1;
                    d_we_d    = MemWrite_in;
                    d_addr_d  = ALU_Result_in;
                    d_wdata_d = r_data2_in;
                    rw_d      = 1'b0;
                    m2r_d     = 1'b0;
                    wwd_d     = 1'b0;
                end else begin
                    rdata_d = '0;
                    alu_d   = ALU_Result_in;
                    rd_d    = rd_in;
                    rw_d    = RegWrite_in;
                    m2r_d   = MemtoReg_in;
                    wwd_d   = is_wwd_in;
                end
            end
            ACCESS: begin
                stall_out = ~d_ack & ~at_limit;
                if (d_ack || at_limit) begin
                    // EX/MEM was held by the stall, so its values still belong to this access
                    cnt_d   = '0;
                    d_req_d = 1'b0;
                    alu_d   = ALU_Result_in;
                    rd_d    = rd_in;
                    m2r_d   = MemtoReg_in;
                    wwd_d   = is_wwd_in;
                    if (d_ack) begin
                        rdata_d = d_we_q ? '0 : d_rdata;
                        rw_d    = RegWrite_in;
                    end else begin
                        rdata_d = {WORD_SIZE{1'b1}};
                        rw_d    = 1'b0;
                        err_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    rw_d  = 1'b0;
                    m2r_d = 1'b0;
                    wwd_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Registered datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            d_req_q   <= 1'b0;
            d_we_q    <= 1'b0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            rdata_q   <= '0;
            alu_q     <= '0;
            rd_q      <= '0;
            rw_q      <= 1'b0;
            m2r_q     <= 1'b0;
            wwd_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            d_req_q   <= d_req_d;
            d_we_q    <= d_we_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
            rdata_q   <= rdata_d;
            alu_q     <= alu_d;
            rd_q      <= rd_d;
            rw_q      <= rw_d;
            m2r_q     <= m2r_d;
            wwd_q     <= wwd_d;
            err_q     <= err_d;
        end
    end

    assign d_req          = d_req_q;
    assign d_we           = d_we_q;
    assign d_addr         = d_addr_q;
    assign d_wdata        = d_wdata_q;
    assign mem_rdata_out  = rdata_q;
    assign ALU_Result_out = alu_q;
    assign rd_out         = rd_q;
    assign RegWrite_out   = rw_q;
    assign MemtoReg_out   = m2r_q;
    assign is_wwd_out     = wwd_q;
    assign mem_err        = err_q;

endmodule
